// File: rtl/protocol_framer_pkg.sv
// protocol_framer_pkg: shared constants and types for the protocol framer.
//   - default SOF/ON/OFF codes and switch threshold
//   - FSM state encoding (3 bits: IDLE=0, SOF=1, CH=2, CKSUM=3, DONE=4)
//   - SOF clamp value and helper that keeps 8'hFF out of the payload
package protocol_framer_pkg;

  localparam logic [7:0] DEF_SOF_BYTE  = 8'hFF;
  localparam logic [7:0] DEF_ON_CODE   = 8'h01;
  localparam logic [7:0] DEF_OFF_CODE  = 8'h02;
  localparam logic [7:0] DEF_SW_THRESH = 8'd20;
  localparam logic [7:0] CLAMP_BYTE    = 8'hFE;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SOF   = 3'd1,
    ST_CH    = 3'd2,
    ST_CKSUM = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [7:0] clamp_sof(input logic [7:0] b);
    return (b == 8'hFF) ? CLAMP_BYTE : b;
  endfunction

endpackage

// File: rtl/protocol_framer_encode.sv
// protocol_encode: combinational channel byte encoder.
//   d   : channel value
//   s   : switch state for the channel
//   enc : ON/OFF code when d < SW_THRESH, else d with 8'hFF clamped to 8'hFE
module protocol_encode
  import protocol_framer_pkg::*;
#(
  parameter logic [7:0] SW_THRESH = DEF_SW_THRESH,
  parameter logic [7:0] ON_CODE   = DEF_ON_CODE,
  parameter logic [7:0] OFF_CODE  = DEF_OFF_CODE
) (
  input  logic [7:0] d,
  input  logic       s,
  output logic [7:0] enc
);

  always_comb begin
    if (d < SW_THRESH) enc = s ? ON_CODE : OFF_CODE;
    else               enc = clamp_sof(d);
  end

endmodule

// File: rtl/protocol_framer.sv
// protocol_framer: builds SOF + N_CH encoded channel bytes (+ optional XOR
// checksum) and streams them over a valid/ready byte interface.
//   clk, reset(async, active low)
//   start            : frame request (ignored unless idle)
//   ch_data, ch_sig  : channel values / switch bits, snapshotted on start
//   tx_valid/tx_data : byte output, held stable until tx_ready
//   tx_ready         : sink accepts byte
//   busy             : frame in progress
//   frame_done       : one-cycle pulse after the last byte is accepted
// Optional checksum byte enabled with macro PROTOCOL_CKSUM_EN.
module protocol_framer
  import protocol_framer_pkg::*;
#(
  parameter int         N_CH      = 4,
  parameter logic [7:0] SW_THRESH = DEF_SW_THRESH,
  parameter logic [7:0] SOF_BYTE  = DEF_SOF_BYTE,
  parameter logic [7:0] ON_CODE   = DEF_ON_CODE,
  parameter logic [7:0] OFF_CODE  = DEF_OFF_CODE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [8*N_CH-1:0] ch_data,
  input  logic [N_CH-1:0]   ch_sig,
  input  logic              tx_ready,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  output logic              busy,
  output logic              frame_done
);

  localparam int            IW   = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [IW-1:0] LAST = IW'(N_CH - 1);

  state_t                 state;
  logic [IW-1:0]          idx, sel;
  logic [N_CH-1:0][7:0]   snap_data;
  logic [N_CH-1:0]        snap_sig;
  logic [7:0]             enc;

  // The encoder looks one byte ahead: it produces the byte that follows
  // the one currently on tx_data, so the output register can load it on
  // the transfer edge and keep back-to-back throughput.
  always_comb begin
    sel = '0;
    if (state == ST_CH && idx != LAST) sel = idx + IW'(1);
  end

  protocol_encode #(
    .SW_THRESH (SW_THRESH),
    .ON_CODE   (ON_CODE),
    .OFF_CODE  (OFF_CODE)
  ) u_enc (
    .d   (snap_data[sel]),
    .s   (snap_sig[sel]),
    .enc (enc)
  );

`ifdef PROTOCOL_CKSUM_EN
  logic [7:0] cksum, cksum_nxt;
  assign cksum_nxt = cksum ^ tx_data;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      idx        <= '0;
      snap_data  <= '0;
      snap_sig   <= '0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef PROTOCOL_CKSUM_EN
      cksum      <= 8'h00;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          snap_data <= ch_data;
          snap_sig  <= ch_sig;
          idx       <= '0;
`ifdef PROTOCOL_CKSUM_EN
          cksum     <= 8'h00;
`endif
          state     <= ST_SOF;
        end
        // First SOF cycle presents the marker; afterwards wait for the sink.
        ST_SOF: begin
          if (!tx_valid) begin
            tx_valid <= 1'b1;
            tx_data  <= SOF_BYTE;
            busy     <= 1'b1;
          end else if (tx_ready) begin
            tx_data <= enc;
            idx     <= '0;
            state   <= ST_CH;
          end
        end
        ST_CH: if (tx_ready) begin
`ifdef PROTOCOL_CKSUM_EN
          cksum <= cksum_nxt;
`endif
          if (idx == LAST) begin
`ifdef PROTOCOL_CKSUM_EN
            tx_data <= clamp_sof(cksum_nxt);
            state   <= ST_CKSUM;
`else
            tx_valid   <= 1'b0;
            frame_done <= 1'b1;
            state      <= ST_DONE;
`endif
          end else begin
            idx     <= idx + IW'(1);
            tx_data <= enc;
          end
        end
`ifdef PROTOCOL_CKSUM_EN
        ST_CKSUM: if (tx_ready) begin
          tx_valid   <= 1'b0;
          frame_done <= 1'b1;
          state      <= ST_DONE;
        end
`endif
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
